fixed_abs_sched: RTL

//  Round-robin scheduler sharing one pipelined 32-bit signed fixed-point absolute-value unit among N_REQ requesters.

---
 rtl/fixed_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 63 ++++++
 rtl/fixed_abs_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fixed_pkg.sv
// rtl/fixed_pkg.sv - shared 32-bit signed fixed-point types, limits and the wrapping abs helper
package fixed_pkg;

    localparam int FIXED_W    = 32;
    localparam int FIXED_FRAC = 16;   // Q16.16

    typedef logic signed [FIXED_W-1:0] fixed_t;

    localparam fixed_t FIXED_MIN = 32'sh8000_0000;
    localparam fixed_t FIXED_MAX = 32'sh7FFF_FFFF;

    // Plain two's complement magnitude; FIXED_MIN maps onto itself.
    function automatic fixed_t fixed_abs_wrap(input fixed_t a);
        return a[FIXED_W-1] ? -a : a;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant with a registered rotating pointer
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   req[N-1:0]  request vector
//   en          grant enable; no grant and no pointer move while low
//   gnt[N-1:0]  one-hot (or zero) grant, combinational from req/en
//   ptr         current search start; moves to winner+1 whenever a grant is issued
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW:0]   pos;
    logic [PW:0]   nxt;
    logic          found;

    // Walk the requesters starting at ptr_q, wrapping modulo N, and take the
    // first asserted one. The extra bit on pos/nxt keeps the wrap exact for
    // non power-of-two N.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        pos   = '0;
        nxt   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr_q} + (PW+1)'(k);
            if (pos >= (PW+1)'(N)) begin
                pos = pos - (PW+1)'(N);
            end
            if (!found && en && req[pos[PW-1:0]]) begin
                found              = 1'b1;
                gnt[pos[PW-1:0]]   = 1'b1;
                nxt                = pos + 1'b1;
                if (nxt >= (PW+1)'(N)) begin
                    nxt = '0;
                end
                ptr_d = nxt[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fixed_abs_sched.sv
// rtl/fixed_abs_sched.sv - round-robin shared pipelined fixed-point abs unit (option macro: FIXED_ABS_SAT_EN)
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   req_valid    per-requester operand valid
//   req_data     operands, requester i at [32*i+31:32*i]
//   req_ready    one-hot (or zero) accept strobe, combinational from req_valid
//   rsp_valid    result valid
//   rsp_data     |operand|
//   rsp_id       originating requester index
//   rsp_sat      result saturated (only with FIXED_ABS_SAT_EN, else 0)
//   rsp_ready    consumer accepts result
//   busy         any pipeline stage holds a valid entry
//
// FIXED_ABS_SAT_EN: when defined, 0x8000_0000 returns 0x7FFF_FFFF with rsp_sat=1;
// otherwise it wraps to 0x8000_0000 and no saturation logic exists.
module fixed_abs_sched
    import fixed_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*32-1:0]  req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_sat,
    input  logic                 rsp_ready,
    output logic                 busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic              advance;
    logic [N_REQ-1:0]  gnt;
    logic [PW-1:0]     ptr_unused;

    logic              vld_q [LAT];
    fixed_t            dat_q [LAT];
    logic [ID_W-1:0]   id_q  [LAT];

    fixed_t            sel_data;
    logic [ID_W-1:0]   sel_id;
    fixed_t            abs_data;

    // The whole pipe moves together; a held result freezes every stage and
    // suppresses new grants so nothing is accepted into a stalled pipe.
    assign advance = !rsp_valid || rsp_ready;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (advance),
        .gnt   (gnt),
        .ptr   (ptr_unused)
    );

    assign req_ready = gnt;

    // gnt is one-hot, so the last match is the only match.
    always_comb begin
        sel_data = '0;
        sel_id   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_data = req_data[32*i +: 32];
                sel_id   = ID_W'(i);
            end
        end
    end

`ifdef FIXED_ABS_SAT_EN
    logic abs_sat;
    logic sat_q [LAT];

    always_comb begin
        abs_sat  = (sel_data == FIXED_MIN);
        abs_data = abs_sat ? FIXED_MAX : fixed_abs_wrap(sel_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                sat_q[k] <= 1'b0;
            end
        end else if (advance) begin
            sat_q[0] <= abs_sat && (|gnt);
            for (int k = 1; k < LAT; k++) begin
                sat_q[k] <= sat_q[k-1];
            end
        end
    end

    assign rsp_sat = sat_q[LAT-1];
`else
    assign abs_data = fixed_abs_wrap(sel_data);
    assign rsp_sat  = 1'b0;
`endif

    // Stage 0 captures the finished abs; later stages are pure delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                vld_q[k] <= 1'b0;
                dat_q[k] <= '0;
                id_q[k]  <= '0;
            end
        end else if (advance) begin
            vld_q[0] <= |gnt;
            dat_q[0] <= abs_data;
            id_q[0]  <= sel_id;
            for (int k = 1; k < LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                dat_q[k] <= dat_q[k-1];
                id_q[k]  <= id_q[k-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            busy = busy | vld_q[k];
        end
    end

    assign rsp_valid = vld_q[LAT-1];
    assign rsp_data  = dat_q[LAT-1];
    assign rsp_id    = id_q[LAT-1];

endmodule
